// File: rtl/relay_mod_ctrl.sv
// Modulation scheduler for the HF relay path: chooses listen/modulate codes for
// hi_iso14443a from the relay bitstream in fake-reader/fake-tag mode, else passes through.
module relay_mod_ctrl #(
   parameter int PRESCALE    = 8,
   parameter int HOLD_TICKS  = 16,
   parameter int GUARD_TICKS = 4
) (
   input  logic       ck_1356meg,
   input  logic       rst,
   input  logic [2:0] conf_mod_type,
   input  logic       relay_in,
   input  logic       ssp_dout,
   output logic [2:0] mod_type,
   output logic       hisn_ssp_dout,
   output logic       relay_active,
   output logic [7:0] mod_count,
   output logic [1:0] o_dbg_state
);

   localparam int PW = (PRESCALE    > 1) ? $clog2(PRESCALE)    : 1;
   localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
   localparam int GW = (GUARD_TICKS > 1) ? $clog2(GUARD_TICKS) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);
   localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_TICKS - 1);

   localparam logic [2:0] CODE_READER = 3'b101;
   localparam logic [2:0] CODE_TAG    = 3'b110;

   typedef enum logic [1:0] {
      ST_PASS   = 2'd0,
      ST_LISTEN = 2'd1,
      ST_MOD    = 2'd2,
      ST_GUARD  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic          r_sync1;
   logic          r_sync2;
   logic [PW-1:0] r_presc;
   logic [HW-1:0] r_hold_cnt;
   logic [HW-1:0] w_next_hold;
   logic [GW-1:0] r_guard_cnt;
   logic [GW-1:0] w_next_guard;
   logic [7:0]    r_mod_count;
   logic [2:0]    r_prev_conf;
   logic          w_tick;
   logic          w_relay_mode;
   logic          w_prev_relay;
   logic          w_swap;
   logic          w_mod_start;
   logic [2:0]    w_code_l;
   logic [2:0]    w_code_m;

   assign w_tick       = (r_presc == PRESC_MAX);
   assign w_relay_mode = (conf_mod_type == CODE_READER) || (conf_mod_type == CODE_TAG);
   assign w_prev_relay = (r_prev_conf == CODE_READER) || (r_prev_conf == CODE_TAG);
   // A direct reader<->tag change forces a guard so the carrier never flips code mid-burst.
   assign w_swap       = w_relay_mode && w_prev_relay && (r_prev_conf != conf_mod_type);

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_presc     <= '0;
         r_prev_conf <= '0;
      end else begin
         r_sync1     <= relay_in;
         r_sync2     <= r_sync1;
         r_presc     <= w_tick ? '0 : r_presc + PW'(1);
         r_prev_conf <= conf_mod_type;
      end
   end

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_state     <= ST_PASS;
         r_hold_cnt  <= '0;
         r_guard_cnt <= '0;
         r_mod_count <= '0;
      end else begin
         r_state     <= w_next_state;
         r_hold_cnt  <= w_next_hold;
         r_guard_cnt <= w_next_guard;
         if (w_mod_start && (r_mod_count != 8'hFF)) begin
            r_mod_count <= r_mod_count + 8'd1;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_hold  = r_hold_cnt;
      w_next_guard = r_guard_cnt;
      w_mod_start  = 1'b0;
      if (!w_relay_mode) begin
         w_next_state = ST_PASS;
      end else if (w_swap && (r_state != ST_PASS)) begin
         w_next_state = ST_GUARD;
         w_next_guard = '0;
      end else if (r_state == ST_PASS) begin
         w_next_state = ST_LISTEN;
      end else if (w_tick) begin
         case (r_state)
            ST_LISTEN: begin
               if (r_sync2) begin
                  w_next_state = ST_MOD;
                  w_next_hold  = '0;
                  w_mod_start  = 1'b1;
               end
            end
            ST_MOD: begin
               if (r_sync2) begin
                  w_next_hold = '0;
               end else if (r_hold_cnt == HOLD_MAX) begin
                  w_next_state = ST_GUARD;
                  w_next_guard = '0;
               end else begin
                  w_next_hold = r_hold_cnt + HW'(1);
               end
            end
            ST_GUARD: begin
               if (r_guard_cnt == GUARD_MAX) begin
                  w_next_state = ST_LISTEN;
               end else begin
                  w_next_guard = r_guard_cnt + GW'(1);
               end
            end
            default: begin
               w_next_state = ST_PASS;
            end
         endcase
      end
   end

   // Listen/modulate codes always follow the live configuration word.
   always_comb begin
      w_code_l = 3'b001;
      w_code_m = 3'b010;
      if (conf_mod_type == CODE_TAG) begin
         w_code_l = 3'b011;
         w_code_m = 3'b100;
      end
   end

   always_comb begin
      mod_type      = conf_mod_type;
      hisn_ssp_dout = ssp_dout;
      case (r_state)
         ST_LISTEN, ST_GUARD: begin
            mod_type      = w_code_l;
            hisn_ssp_dout = r_sync2;
         end
         ST_MOD: begin
            mod_type      = w_code_m;
            hisn_ssp_dout = r_sync2;
         end
         default: begin
            mod_type      = conf_mod_type;
            hisn_ssp_dout = ssp_dout;
         end
      endcase
   end

   assign relay_active = (r_state == ST_MOD);
   assign mod_count    = r_mod_count;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_relay_mod_ctrl.sv
// Directed bench for relay_mod_ctrl: a vector table for pass-through/mode entry and
// cycle-counted sequences for bursts, guard, mode swaps, reset and saturation.
module tb_relay_mod_ctrl;

   localparam logic [1:0] ST_PASS   = 2'd0;
   localparam logic [1:0] ST_LISTEN = 2'd1;
   localparam logic [1:0] ST_MOD    = 2'd2;
   localparam logic [1:0] ST_GUARD  = 2'd3;

   logic       ck_1356meg = 1'b0;
   logic       rst;
   logic [2:0] conf_mod_type;
   logic       relay_in;
   logic       ssp_dout;
   logic [2:0] mod_type;
   logic       hisn_ssp_dout;
   logic       relay_active;
   logic [7:0] mod_count;
   logic [1:0] o_dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int exp_cnt  = 0;
   int n;

   typedef struct {
      logic [2:0] conf;
      logic       ssp;
      logic       chk_now;
      logic [2:0] mt_now;
      logic       hisn_now;
      logic [2:0] mt_next;
      logic       hisn_next;
      logic [1:0] st_next;
   } vec_t;

   vec_t vecs[11];

   always #5 ck_1356meg = ~ck_1356meg;

   relay_mod_ctrl #(
      .PRESCALE   (8),
      .HOLD_TICKS (16),
      .GUARD_TICKS(4)
   ) dut (
      .ck_1356meg   (ck_1356meg),
      .rst          (rst),
      .conf_mod_type(conf_mod_type),
      .relay_in     (relay_in),
      .ssp_dout     (ssp_dout),
      .mod_type     (mod_type),
      .hisn_ssp_dout(hisn_ssp_dout),
      .relay_active (relay_active),
      .mod_count    (mod_count),
      .o_dbg_state  (o_dbg_state)
   );

   // cyc tracks the prescaler phase: cyc % 8 equals the prescaler value after reset.
   task automatic step();
      @(posedge ck_1356meg);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // From LISTEN: one-cycle relay pulse timed so the synchronised bit lands on a tick.
   task automatic enter_mod(input string name);
      for (int i = 0; (i < 8) && ((cyc % 8) != 5); i++) step();
      relay_in = 1'b1;
      step();
      relay_in = 1'b0;
      step();
      step();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk(name, 32'(o_dbg_state), 32'(ST_MOD));
   endtask

   task automatic count_state(input logic [1:0] st, output int cnt);
      cnt = 0;
      while ((o_dbg_state == st) && (cnt < 1000)) begin
         cnt++;
         step();
      end
   endtask

   task automatic wait_listen(input string name);
      for (int i = 0; (i < 400) && (o_dbg_state != ST_LISTEN); i++) step();
      chk(name, 32'(o_dbg_state), 32'(ST_LISTEN));
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{3'b010, 1'b1, 1'b1, 3'b010, 1'b1, 3'b010, 1'b1, ST_PASS};
      vecs[1]  = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 3'b010, 1'b0, ST_PASS};
      vecs[2]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b1, 3'b000, 1'b1, ST_PASS};
      vecs[3]  = '{3'b111, 1'b0, 1'b1, 3'b111, 1'b0, 3'b111, 1'b0, ST_PASS};
      vecs[4]  = '{3'b101, 1'b1, 1'b1, 3'b101, 1'b1, 3'b001, 1'b0, ST_LISTEN};
      vecs[5]  = '{3'b101, 1'b0, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0, ST_LISTEN};
      vecs[6]  = '{3'b110, 1'b1, 1'b1, 3'b011, 1'b0, 3'b011, 1'b0, ST_GUARD};
      vecs[7]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b0, 3'b011, 1'b1, ST_PASS};
      vecs[8]  = '{3'b100, 1'b0, 1'b1, 3'b100, 1'b0, 3'b100, 1'b0, ST_PASS};
      vecs[9]  = '{3'b110, 1'b1, 1'b1, 3'b110, 1'b1, 3'b011, 1'b0, ST_LISTEN};
      vecs[10] = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 3'b001, 1'b1, ST_PASS};

      // Reset values
      rst = 1'b1;
      conf_mod_type = 3'b010;
      relay_in = 1'b0;
      ssp_dout = 1'b1;
      repeat (3) step();
      chk("rst_mod_type", 32'(mod_type), 32'(3'b010));
      chk("rst_hisn", 32'(hisn_ssp_dout), 32'(1'b1));
      chk("rst_active", 32'(relay_active), 32'(1'b0));
      chk("rst_count", 32'(mod_count), 32'(0));
      chk("rst_state", 32'(o_dbg_state), 32'(ST_PASS));
      rst = 1'b0;
      cyc = 0;

      // Pass-through, relay entry/exit and a swap out of LISTEN
      for (int i = 0; i < 11; i++) begin
         conf_mod_type = vecs[i].conf;
         ssp_dout = vecs[i].ssp;
         #1;
         if (vecs[i].chk_now) begin
            chk($sformatf("vec%0d_mt_now", i), 32'(mod_type), 32'(vecs[i].mt_now));
            chk($sformatf("vec%0d_hisn_now", i), 32'(hisn_ssp_dout), 32'(vecs[i].hisn_now));
         end
         step();
         chk($sformatf("vec%0d_mt_next", i), 32'(mod_type), 32'(vecs[i].mt_next));
         chk($sformatf("vec%0d_hisn_next", i), 32'(hisn_ssp_dout), 32'(vecs[i].hisn_next));
         chk($sformatf("vec%0d_state", i), 32'(o_dbg_state), 32'(vecs[i].st_next));
         chk($sformatf("vec%0d_active", i), 32'(relay_active), 32'(1'b0));
         chk($sformatf("vec%0d_count", i), 32'(mod_count), 32'(0));
      end

      // Single burst: 8-cycle relay pulse, MOD lasts 16 ticks, GUARD 4 ticks
      conf_mod_type = 3'b101;
      step();
      chk("s1_listen_mt", 32'(mod_type), 32'(3'b001));
      relay_in = 1'b1;
      n = 0;
      for (int c = 1; c < 400; c++) begin
         step();
         if (c == 8) relay_in = 1'b0;
         if (o_dbg_state == ST_MOD) begin
            if (n == 0) chk("s1_mod_mt", 32'(mod_type), 32'(3'b010));
            n++;
         end else if (n != 0) begin
            break;
         end
      end
      exp_cnt = 1;
      chk("s1_mod_len", 32'(n), 32'(128));
      chk("s1_guard_mt", 32'(mod_type), 32'(3'b001));
      count_state(ST_GUARD, n);
      chk("s1_guard_len", 32'(n), 32'(32));
      chk("s1_listen_state", 32'(o_dbg_state), 32'(ST_LISTEN));
      chk("s1_count", 32'(mod_count), 32'(1));

      // Relay pulse inside GUARD is ignored
      enter_mod("s2_enter");
      count_state(ST_MOD, n);
      chk("s2_mod_len", 32'(n), 32'(128));
      relay_in = 1'b1;
      n = 0;
      for (int c = 0; c < 100; c++) begin
         if (c == 8) relay_in = 1'b0;
         if (o_dbg_state != ST_GUARD) break;
         n++;
         step();
      end
      chk("s2_guard_len", 32'(n), 32'(32));
      chk("s2_listen", 32'(o_dbg_state), 32'(ST_LISTEN));
      repeat (16) step();
      chk("s2_still_listen", 32'(o_dbg_state), 32'(ST_LISTEN));
      chk("s2_count", 32'(mod_count), 32'(exp_cnt));

      // High tick at low-tick 10 restarts the hold: 10 + 16 ticks of MOD
      enter_mod("s3_enter");
      n = 1;
      for (int c = 1; c < 400; c++) begin
         step();
         if (c == 72) relay_in = 1'b1;
         if (c == 80) relay_in = 1'b0;
         if (o_dbg_state != ST_MOD) break;
         n++;
      end
      chk("s3_mod_len", 32'(n), 32'(208));
      count_state(ST_GUARD, n);
      chk("s3_guard_len", 32'(n), 32'(32));
      chk("s3_count", 32'(mod_count), 32'(exp_cnt));

      // Reader -> tag swap in MOD
      enter_mod("s4_enter");
      for (int c = 1; c <= 20; c++) step();
      conf_mod_type = 3'b110;
      #1;
      chk("s4_mt_live", 32'(mod_type), 32'(3'b100));
      step();
      chk("s4_guard_mt", 32'(mod_type), 32'(3'b011));
      chk("s4_guard_state", 32'(o_dbg_state), 32'(ST_GUARD));
      count_state(ST_GUARD, n);
      chk("s4_guard_len", 32'(n), 32'(27));
      chk("s4_listen_state", 32'(o_dbg_state), 32'(ST_LISTEN));
      chk("s4_listen_mt", 32'(mod_type), 32'(3'b011));
      enter_mod("s4_reenter");
      chk("s4_mod_mt", 32'(mod_type), 32'(3'b100));
      chk("s4_active", 32'(relay_active), 32'(1'b1));
      chk("s4_count", 32'(mod_count), 32'(exp_cnt));

      // Swap back on the very edge GUARD would finish: swap wins, guard restarts
      for (int c = 1; c <= 20; c++) step();
      conf_mod_type = 3'b101;
      step();
      chk("s5_guard_mt", 32'(mod_type), 32'(3'b001));
      chk("s5_guard_state", 32'(o_dbg_state), 32'(ST_GUARD));
      n = 1;
      for (int c = 22; c < 200; c++) begin
         step();
         if (c == 47) conf_mod_type = 3'b110;
         if (o_dbg_state != ST_GUARD) break;
         n++;
      end
      chk("s5_guard_len", 32'(n), 32'(59));
      chk("s5_listen_mt", 32'(mod_type), 32'(3'b011));
      chk("s5_count", 32'(mod_count), 32'(exp_cnt));

      // Leaving relay mode from MOD
      enter_mod("s6_enter");
      ssp_dout = 1'b1;
      conf_mod_type = 3'b000;
      step();
      chk("s6_mt", 32'(mod_type), 32'(3'b000));
      chk("s6_hisn", 32'(hisn_ssp_dout), 32'(1'b1));
      chk("s6_state", 32'(o_dbg_state), 32'(ST_PASS));
      chk("s6_active", 32'(relay_active), 32'(1'b0));
      ssp_dout = 1'b0;
      #1;
      chk("s6_hisn_follow", 32'(hisn_ssp_dout), 32'(1'b0));
      chk("s6_count", 32'(mod_count), 32'(exp_cnt));

      // Reset mid-MOD
      conf_mod_type = 3'b101;
      step();
      enter_mod("s7_enter");
      repeat (5) step();
      chk("s7_in_mod", 32'(o_dbg_state), 32'(ST_MOD));
      ssp_dout = 1'b1;
      rst = 1'b1;
      step();
      chk("s7_state", 32'(o_dbg_state), 32'(ST_PASS));
      chk("s7_count", 32'(mod_count), 32'(0));
      chk("s7_mt", 32'(mod_type), 32'(3'b101));
      chk("s7_hisn", 32'(hisn_ssp_dout), 32'(1'b1));
      chk("s7_active", 32'(relay_active), 32'(1'b0));
      rst = 1'b0;
      cyc = 0;
      exp_cnt = 0;
      step();
      chk("s7_relisten", 32'(o_dbg_state), 32'(ST_LISTEN));
      enter_mod("s7_after_rst");
      chk("s7_count_after", 32'(mod_count), 32'(1));
      wait_listen("s7_back");

      // Saturation of mod_count
      rst = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0;
      exp_cnt = 0;
      step();
      for (int b = 1; b <= 300; b++) begin
         enter_mod($sformatf("s8_burst%0d", b));
         wait_listen($sformatf("s8_back%0d", b));
         if ((b == 100) || (b == 255) || (b == 300)) begin
            chk($sformatf("s8_count_%0d", b), 32'(mod_count), 32'(exp_cnt));
         end
      end
      chk("s8_saturated", 32'(mod_count), 32'(255));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
